// File: rtl/sort_column_ctrl_if.sv
// Purpose: column stream bundle between pixel source, sort_column_ctrl and the 7-lane sorter.
// Latency: none; wires only.
// Backpressure: in_valid/in_ready handshake on the upstream side; the sorter side is free-running.
// Ports: in_valid/in_ready/in_eol/in_col from the window source; sort_refresh/sort_in to the
//        sorter; out_valid/out_eol/out_eof qualify the sorter outputs.
interface sort_column_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 7
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_eol;
    logic [LANES*DATA_WIDTH-1:0]   in_col;
    logic                          sort_refresh;
    logic [LANES*DATA_WIDTH-1:0]   sort_in;
    logic                          out_valid;
    logic                          out_eol;
    logic                          out_eof;

    // master: the environment (column source + sorter output consumer)
    modport master (
        output in_valid, in_eol, in_col,
        input  in_ready, sort_refresh, sort_in, out_valid, out_eol, out_eof
    );

    // slave: the sequencer
    modport slave (
        input  in_valid, in_eol, in_col,
        output in_ready, sort_refresh, sort_in, out_valid, out_eol, out_eof
    );
endinterface

// File: rtl/sort_column_ctrl.sv
// Purpose: frame sequencer gating 7-pixel columns into the pipelined median sorter.
// Latency: accepted column is flagged on out_valid LATENCY cycles after its accept cycle.
// Backpressure: in_ready high only in RUN (not on an abort cycle); never stalls the sorter.
// Ports: clk, rst (async active-low); start/abort control pulses; cfg_cols/cfg_rows frame
//        size sampled at an accepted start; col_if column stream + sorter control (slave);
//        busy (not IDLE), frame_done (last output pulse), err (sticky protocol error).
module sort_column_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 7,
    parameter int LATENCY    = 14,
    parameter int DIM_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIM_WIDTH-1:0] cfg_cols,
    input  logic [DIM_WIDTH-1:0] cfg_rows,
    sort_column_ctrl_if.slave    col_if,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [DIM_WIDTH-1:0]   cols_q;
    logic [DIM_WIDTH-1:0]   rows_q;
    logic [DIM_WIDTH-1:0]   col_cnt;
    logic [DIM_WIDTH-1:0]   row_cnt;

    // One bit per sorter stage; index LATENCY-1 lines up with the sorter outputs.
    logic [LATENCY-1:0]     tag_vld;
    logic [LATENCY-1:0]     tag_eol;
    logic [LATENCY-1:0]     tag_eof;

    logic                   cfg_ok;
    logic                   start_ok;
    logic                   abort_act;
    logic                   accept;
    logic                   col_last;
    logic                   row_last;
    logic                   frame_last;
    logic                   tag_clr;
    logic                   in_ready;
    logic                   sort_refresh;

    assign cfg_ok     = (cfg_cols != '0) && (cfg_rows != '0);
    assign abort_act  = abort && (state != IDLE);
    assign col_last   = (col_cnt == cols_q - DIM_WIDTH'(1));
    assign row_last   = (row_cnt == rows_q - DIM_WIDTH'(1));
    assign frame_last = col_last && row_last;

    // Abort wins over a beat in the same cycle, so it is folded into ready directly.
    assign in_ready   = (state == RUN) && !abort;
    assign accept     = col_if.in_valid && in_ready;

    // The sorter samples every edge; non-accepted cycles present an all-zero bubble.
    assign col_if.sort_in      = accept ? col_if.in_col : '0;
    assign col_if.in_ready     = in_ready;
    assign col_if.sort_refresh = sort_refresh;
    assign col_if.out_valid    = tag_vld[LATENCY-1];
    assign col_if.out_eol      = tag_eol[LATENCY-1];
    assign col_if.out_eof      = tag_eof[LATENCY-1];
    assign busy                = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        sort_refresh = 1'b0;
        frame_done   = 1'b0;
        start_ok     = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    start_ok  = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                sort_refresh = 1'b1;
                state_nxt    = RUN;
            end
            RUN: begin
                if (accept && frame_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (tag_eof[LATENCY-1]) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort flushes the sorter on the way back to IDLE and suppresses completion.
        if (abort_act) begin
            state_nxt    = IDLE;
            sort_refresh = 1'b1;
            frame_done   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cols_q  <= '0;
            rows_q  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (start_ok) begin
                cols_q <= cfg_cols;
                rows_q <= cfg_rows;
            end

            if (start_ok || abort_act) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + DIM_WIDTH'(1);
                end else begin
                    col_cnt <= col_cnt + DIM_WIDTH'(1);
                end
            end

            // in_eol is only checked; the internal count stays authoritative.
            if (start_ok) begin
                err <= 1'b0;
            end else if ((state == IDLE && start && !cfg_ok) ||
                         (accept && (col_if.in_eol != col_last))) begin
                err <= 1'b1;
            end
        end
    end

    assign tag_clr = (state == CLEAR) || abort_act;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            tag_eol <= '0;
            tag_eof <= '0;
        end else if (tag_clr) begin
            tag_vld <= '0;
            tag_eol <= '0;
            tag_eof <= '0;
        end else begin
            tag_vld <= {tag_vld[LATENCY-2:0], accept};
            tag_eol <= {tag_eol[LATENCY-2:0], accept && col_last};
            tag_eof <= {tag_eof[LATENCY-2:0], accept && frame_last};
        end
    end
endmodule

// File: tb/tb_sort_column_ctrl.sv
`timescale 1ns/1ps
module tb_sort_column_ctrl;
    localparam int DW   = 8;
    localparam int LN   = 7;
    localparam int LAT  = 14;
    localparam int DIMW = 12;
    localparam int CW   = DW * LN;

    logic            clk      = 1'b0;
    logic            rst      = 1'b0;
    logic            start    = 1'b0;
    logic            abort    = 1'b0;
    logic [DIMW-1:0] cfg_cols = '0;
    logic [DIMW-1:0] cfg_rows = '0;
    logic            busy;
    logic            frame_done;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;
    bit err_m    = 1'b0;

    sort_column_ctrl_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

    sort_column_ctrl #(
        .DATA_WIDTH(DW), .LANES(LN), .LATENCY(LAT), .DIM_WIDTH(DIMW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .col_if(bus),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every output quiet (IDLE, nothing in flight).
    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_out_valid", bus.out_valid, 0);
            chk("idle_frame_done", frame_done, 0);
            chk("idle_in_ready", bus.in_ready, 0);
            chk("idle_refresh", bus.sort_refresh, 0);
        end
    endtask

    // Runs one frame starting with a start pulse in cycle 0 and checks every cycle against
    // a beat-level model: beats are numbered 0..cols*rows-1 in acceptance order, beat i is
    // end-of-line when i%cols==cols-1, and appears on the sorter outputs LAT cycles later.
    // mode: 0 = in_valid always 1, 1 = toggling 1,0,1,0 from the first RUN cycle, 2 = random.
    task automatic run_frame(input int cols, input int rows, input int mode, input int bad_idx,
                             input int abort_beat, input bit drain_start, output int act_done);
        int            n_total;
        int            acc;
        int            done_cyc;
        int            abort_cyc;
        bit            aborted;
        bit            abort_now;
        bit            vld;
        bit            ok_eol;
        bit            exp_rdy;
        bit            accd;
        bit            exp_busy;
        logic [2:0]    flg [int];
        logic [2:0]    ef;
        logic [CW-1:0] col;
        n_total   = cols * rows;
        acc       = 0;
        done_cyc  = -1;
        abort_cyc = -1;
        aborted   = 1'b0;
        act_done  = -1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (drain_start && done_cyc >= 0 && c == done_cyc - 5);
            abort_now = !aborted && abort_beat >= 0 && c >= 2 && acc == abort_beat;
            abort     = abort_now;
            if (c == 0) begin
                cfg_cols = DIMW'(cols);
                cfg_rows = DIMW'(rows);
            end else begin
                cfg_cols = DIMW'($urandom_range(0, 7));
                cfg_rows = DIMW'($urandom_range(0, 7));
            end
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (c % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            col          = CW'({$urandom(), $urandom()});
            ok_eol       = ((acc % cols) == cols - 1);
            bus.in_valid = vld;
            bus.in_col   = col;
            bus.in_eol   = ok_eol ^ (acc == bad_idx);

            exp_rdy  = !aborted && c >= 2 && acc < n_total && !abort_now;
            accd     = exp_rdy && vld;
            exp_busy = c >= 1 && !aborted && (done_cyc < 0 || c <= done_cyc);
            ef       = flg.exists(c) ? flg[c] : 3'b000;

            @(negedge clk);
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("sort_refresh", bus.sort_refresh, (c == 1) || abort_now);
            chk("sort_in", bus.sort_in, accd ? col : '0);
            chk("out_valid", bus.out_valid, ef[2]);
            chk("out_eol", bus.out_eol, ef[1]);
            chk("out_eof", bus.out_eof, ef[0]);
            chk("frame_done", frame_done, ef[0] && !abort_now);
            chk("busy", busy, exp_busy);
            chk("err", err, err_m);
            if (frame_done === 1'b1 && act_done < 0) act_done = c;

            if (c == 0) err_m = 1'b0;
            if (accd) begin
                flg[c + LAT] = {1'b1, ok_eol, acc == n_total - 1};
                if (bus.in_eol != ok_eol) err_m = 1'b1;
                acc++;
                if (acc == n_total) done_cyc = c + LAT;
            end
            if (abort_now) begin
                aborted   = 1'b1;
                abort_cyc = c;
                flg.delete();
            end
            if (done_cyc >= 0 && c == done_cyc + 2) break;
            if (aborted && c == abort_cyc + 25) break;
            if (c == 599) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_timeout: frame %0dx%0d did not complete, beats=%0d of %0d",
                         cols, rows, acc, n_total);
            end
        end
        start        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_eol   = 1'b0;
    endtask

    typedef struct {
        int cols;
        int rows;
        int mode;
        int bad_idx;
        int abort_beat;
        bit drain_start;
        int exp_done;   // frame_done cycle relative to start; -1 never; -2 not checked
        bit exp_err;
    } vec_t;

    vec_t vecs [8];
    int   act_done;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_eol   = 1'b0;
        bus.in_col   = '0;

        // Reset state, before any clock edge.
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_refresh", bus.sort_refresh, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_eol", bus.out_eol, 0);
        chk("rst_out_eof", bus.out_eof, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Zero-sized config: error, no frame.
        @(posedge clk); #1;
        start = 1'b1; cfg_cols = '0; cfg_rows = DIMW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_cols_err", err, 1);
        chk("zero_cols_busy", busy, 0);
        chk("zero_cols_refresh", bus.sort_refresh, 0);
        @(posedge clk); #1;
        start = 1'b1; cfg_cols = DIMW'(5); cfg_rows = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_rows_err", err, 1);
        idle_check(3);
        err_m = 1'b1;

        vecs[0] = '{4, 2, 0, -1, -1, 1'b0, 23, 1'b0};
        vecs[1] = '{4, 2, 1, -1, -1, 1'b0, 30, 1'b0};
        vecs[2] = '{4, 2, 0,  2, -1, 1'b0, 23, 1'b1};
        vecs[3] = '{1, 1, 0, -1, -1, 1'b0, 16, 1'b0};
        vecs[4] = '{3, 2, 0, -1, -1, 1'b1, 21, 1'b0};
        vecs[5] = '{4, 2, 0, -1,  2, 1'b0, -1, 1'b0};
        vecs[6] = '{2, 3, 2, -1, -1, 1'b0, -2, 1'b0};
        vecs[7] = '{5, 1, 2,  3, -1, 1'b0, -2, 1'b1};

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].cols, vecs[i].rows, vecs[i].mode, vecs[i].bad_idx,
                      vecs[i].abort_beat, vecs[i].drain_start, act_done);
            if (vecs[i].exp_done != -2) chk("vec_done_cycle", act_done, vecs[i].exp_done);
            chk("vec_err_after", err, vecs[i].exp_err);
        end

        for (int i = 0; i < 6; i++) begin
            int rc, rr, rbad, rab;
            rc   = $urandom_range(1, 4);
            rr   = $urandom_range(1, 3);
            rbad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rc * rr - 1) : -1;
            rab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rc * rr - 1) : -1;
            run_frame(rc, rr, 2, rbad, rab, 1'($urandom_range(0, 1)), act_done);
        end

        // Reset after 5 accepted beats: outputs drop immediately, in-flight columns vanish.
        @(posedge clk); #1;
        start = 1'b1; cfg_cols = DIMW'(4); cfg_rows = DIMW'(2); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_refresh", bus.sort_refresh, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        chk("midrst_sort_in", bus.sort_in, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle_check(25);
        bus.in_valid = 1'b0;
        err_m = 1'b0;
        run_frame(3, 2, 0, -1, -1, 1'b0, act_done);
        chk("post_rst_done_cycle", act_done, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
